// File: rtl/tristate_bus_pkg.sv
// Shared definitions for the tri-state bus port: TX FSM state encoding and default sizes.
package tristate_bus_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    TURN  = 2'd2
  } tx_state_e;

endpackage

// File: rtl/tristate_rx_fifo.sv
// Synchronous RX FIFO: pointer pair plus occupancy count, drop-on-full with a one-cycle
// overflow pulse. A push is still accepted when full if a pop happens in the same cycle.
module tristate_rx_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic             overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = DEPTH[AW:0];
  localparam logic [AW:0]   CNT_ONE  = 1;
  localparam logic [AW-1:0] PTR_ONE  = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;
  logic             drop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  // A pop frees the slot in the same cycle, so a full FIFO still takes the incoming word.
  assign do_push = push & (~full | do_pop);
  assign drop    = push & full & ~do_pop;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= drop;
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/tristate_bus_port.sv
// Endpoint on the shared tri-state bus: captures remote words into an RX FIFO and drives
// local words via an IDLE/DRIVE/TURN FSM. Optional dropped-word counter: TRISTATE_PORT_OVF_CNT_EN.
module tristate_bus_port
  import tristate_bus_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  inout  wire  [WIDTH-1:0] bus,
  input  logic             bus_en_in,
  output logic             bus_en_out,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             rx_overflow,
`ifdef TRISTATE_PORT_OVF_CNT_EN
  output logic [7:0]       ovf_count,
`endif
  output logic             collision
);

  // Valid/ready: a TX word moves when tx_valid & tx_ready at a rising edge; an RX word
  // leaves the FIFO when rx_valid & rx_ready at a rising edge. Neither side may retract.
  tx_state_e        state;
  tx_state_e        state_d;
  logic             accept;
  logic [WIDTH-1:0] tx_word;
  logic             rx_empty;
  logic             rx_full;

  always_comb begin
    state_d  = state;
    tx_ready = 1'b0;
    accept   = 1'b0;
    case (state)
      IDLE: begin
        tx_ready = ~bus_en_in;
        if (tx_valid && !bus_en_in) begin
          accept  = 1'b1;
          state_d = DRIVE;
        end
      end
      DRIVE:   state_d = TURN;
      TURN:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      bus_en_out <= 1'b0;
      tx_word    <= '0;
      collision  <= 1'b0;
    end else begin
      state      <= state_d;
      bus_en_out <= (state_d == DRIVE);
      if (accept) tx_word <= tx_data;
      if (state == DRIVE && bus_en_in) collision <= 1'b1;
    end
  end

  assign bus = bus_en_out ? tx_word : {WIDTH{1'bz}};

  // Our own DRIVE cycle is never looped back into the RX path.
  tristate_rx_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_rx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (bus_en_in && (state != DRIVE)),
    .din     (bus),
    .pop     (rx_ready),
    .head    (rx_data),
    .full    (rx_full),
    .empty   (rx_empty),
    .overflow(rx_overflow)
  );

  assign rx_valid = ~rx_empty;

`ifdef TRISTATE_PORT_OVF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_count <= '0;
    else if (rx_overflow && ovf_count != 8'hFF) ovf_count <= ovf_count + 8'd1;
  end
`endif

  logic unused_full;
  assign unused_full = rx_full;

endmodule

// File: tb/tb_tristate_bus_port.sv
// Bench for tristate_bus_port: directed bus scenarios plus random traffic against a
// cycle-count/queue reference model. Honours TRISTATE_PORT_OVF_CNT_EN when defined.
module tb_tristate_bus_port;

  localparam int W = 4;
  localparam int D = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wire  [W-1:0] bus;
  logic         bus_en_in = 1'b0;
  logic [W-1:0] remote_data = '0;
  logic         bus_en_out;
  logic [W-1:0] tx_data = '0;
  logic         tx_valid = 1'b0;
  logic         tx_ready;
  logic [W-1:0] rx_data;
  logic         rx_valid;
  logic         rx_ready = 1'b0;
  logic         rx_overflow;
  logic         collision;
`ifdef TRISTATE_PORT_OVF_CNT_EN
  logic [7:0]   ovf_count;
`endif

  assign bus = bus_en_in ? remote_data : {W{1'bz}};

  tristate_bus_port #(.WIDTH(W), .DEPTH(D)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .bus_en_in  (bus_en_in),
    .bus_en_out (bus_en_out),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .rx_overflow(rx_overflow),
`ifdef TRISTATE_PORT_OVF_CNT_EN
    .ovf_count  (ovf_count),
`endif
    .collision  (collision)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: TX timing derived from the cycle of the last accepted word.
  int           cyc = 0;
  int           last_acc = -10;
  logic [W-1:0] tx_word = '0;
  logic [W-1:0] exp_q[$];
  logic         ovf_exp = 1'b0;
  logic         coll_exp = 1'b0;
  int           ovf_cnt_exp = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    last_acc    = cyc - 10;
    ovf_exp     = 1'b0;
    coll_exp    = 1'b0;
    ovf_cnt_exp = 0;
  endtask

  task automatic step(input logic en, input logic [W-1:0] rd, input logic tv,
                      input logic [W-1:0] td, input logic rr);
    logic drive_now;
    logic idle;
    logic drop;
    @(negedge clk);
    bus_en_in   = en;
    remote_data = rd;
    tx_valid    = tv;
    tx_data     = td;
    rx_ready    = rr;
    #1;
    drive_now = (cyc == last_acc + 1);
    idle      = (cyc >= last_acc + 3);
    chk("tx_ready", tx_ready, idle && !en);
    chk("bus_en_out", bus_en_out, drive_now);
    if (drive_now && !en) chk("bus_word", bus, tx_word);
    if (!drive_now && en) chk("bus_remote", bus, rd);
    chk("rx_valid", rx_valid, exp_q.size() > 0);
    if (exp_q.size() > 0) chk("rx_data", rx_data, exp_q[0]);
    chk("rx_overflow", rx_overflow, ovf_exp);
    chk("collision", collision, coll_exp);
`ifdef TRISTATE_PORT_OVF_CNT_EN
    chk("ovf_count", ovf_count, ovf_cnt_exp);
    if (ovf_exp && ovf_cnt_exp < 255) ovf_cnt_exp++;
`endif
    drop = 1'b0;
    if (rr && exp_q.size() > 0) void'(exp_q.pop_front());
    if (en && !drive_now) begin
      if (exp_q.size() < D) exp_q.push_back(rd);
      else drop = 1'b1;
    end
    ovf_exp = drop;
    if (drive_now && en) coll_exp = 1'b1;
    if (tv && idle && !en) begin
      last_acc = cyc;
      tx_word  = td;
    end
    cyc++;
  endtask

  initial begin
    // Reset state
    #1;
    chk("rst_bus_en_out", bus_en_out, 1'b0);
    chk("rst_rx_valid", rx_valid, 1'b0);
    chk("rst_rx_data", rx_data, '0);
    chk("rst_rx_overflow", rx_overflow, 1'b0);
    chk("rst_collision", collision, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // RX ordering
    step(1'b1, 4'b0000, 1'b0, '0, 1'b0);
    step(1'b1, 4'b1010, 1'b0, '0, 1'b0);
    step(1'b1, 4'b1111, 1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0, '0, 1'b1);
    chk("rx_pop0", rx_data, 4'b0000);
    step(1'b0, '0, 1'b0, '0, 1'b1);
    chk("rx_pop1", rx_data, 4'b1010);
    step(1'b0, '0, 1'b0, '0, 1'b1);
    chk("rx_pop2", rx_data, 4'b1111);
    step(1'b0, '0, 1'b0, '0, 1'b0);
    chk("rx_drained", rx_valid, 1'b0);

    // Overflow: five enabled cycles into an empty FIFO of four
    for (int i = 0; i < 5; i++) step(1'b1, W'(i + 3), 1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0, '0, 1'b0);
    chk("ovf_pulse", rx_overflow, 1'b1);
    step(1'b0, '0, 1'b0, '0, 1'b0);
    chk("ovf_once", rx_overflow, 1'b0);
`ifdef TRISTATE_PORT_OVF_CNT_EN
    chk("ovf_count_one", ovf_count, 8'd1);
`endif

    // Full with simultaneous push and pop
    step(1'b1, 4'b1100, 1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0, '0, 1'b0);
    chk("full_pop_no_ovf", rx_overflow, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0, '0, 1'b0);
    chk("full_pop_four", rx_valid, 1'b0);

    // Local TX
    step(1'b0, '0, 1'b1, 4'b0101, 1'b0);
    step(1'b0, '0, 1'b0, '0, 1'b0);
    chk("tx_bus_word", bus, 4'b0101);
    step(1'b0, '0, 1'b1, 4'b0011, 1'b0);
    chk("tx_turn_release", bus_en_out, 1'b0);
    chk("tx_turn_ready", tx_ready, 1'b0);
    step(1'b0, '0, 1'b0, '0, 1'b0);
    chk("tx_ready_again", tx_ready, 1'b1);
    chk("tx_not_captured", rx_valid, 1'b0);

    // Defer while remote drives, then collide during DRIVE
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 4'b0110, 1'b1, 4'b1001, 1'b1);
      chk("defer_ready", tx_ready, 1'b0);
    end
    step(1'b0, '0, 1'b1, 4'b1001, 1'b1);
    chk("defer_accept", tx_ready, 1'b1);
    step(1'b1, 4'b0111, 1'b0, '0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, '0, 1'b0, '0, 1'b1);
      chk("collision_sticky", collision, 1'b1);
    end

    // Random traffic
    for (int i = 0; i < 1500; i++)
      step($urandom_range(0, 99) < 45, W'($urandom), $urandom_range(0, 99) < 50,
           W'($urandom), $urandom_range(0, 99) < 40);

    // Reset while driving, with FIFO occupied and collision set
    repeat (3) step(1'b0, '0, 1'b0, '0, 1'b0);
    step(1'b1, 4'b0101, 1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b1, 4'b0110, 1'b0);
    @(negedge clk);
    tx_valid = 1'b0;
    #1;
    chk("pre_rst_drive", bus_en_out, 1'b1);
    chk("pre_rst_rx_valid", rx_valid, 1'b1);
    chk("pre_rst_collision", collision, coll_exp);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_bus_en_out", bus_en_out, 1'b0);
    chk("mid_rst_rx_valid", rx_valid, 1'b0);
    chk("mid_rst_collision", collision, 1'b0);
    chk("mid_rst_rx_data", rx_data, '0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 200; i++)
      step($urandom_range(0, 99) < 45, W'($urandom), $urandom_range(0, 99) < 50,
           W'($urandom), $urandom_range(0, 99) < 40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
